srl_pipe_ctrl: RTL and testbench

- Flow-control sequencer for a fixed-latency shift-register delay line (srl_bus-style datapath).
- Turns the free-running delay line into a valid/ready stage:
  - drives its clock enable;
  - tracks which slots hold live data;
  - applies downstream back-pressure;
  - sequences a drain (accept nothing new, run until empty, report done).
- Sits between a streaming producer and consumer wherever a fixed N-cycle delay-matching bus is inserted.

---
 rtl/srl_pkg.sv | 20 ++
 rtl/srl_pipe_payload.sv | 30 +++
 rtl/srl_pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_srl_pipe_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_pkg.sv
// Shared definitions for the srl_pipe flow-control block: FSM encoding and
// the legal delay-line depth range.
package srl_pkg;

  localparam int C_SRL_MIN_DEPTH = 2;
  localparam int C_SRL_MAX_DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } srl_state_e;

  // True when a requested delay-line depth is within the supported range.
  function automatic logic depth_ok(input int depth);
    return (depth >= C_SRL_MIN_DEPTH) && (depth <= C_SRL_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/srl_pipe_payload.sv
// Payload half of the delay line: a plain per-bit shift register advanced by
// a clock enable. It carries no reset so it maps onto SRL-style primitives;
// liveness of each slot is tracked separately by the controller.
module srl_pipe_payload
  import srl_pkg::*;
#(
  parameter int C_DEPTH = 4,
  parameter int C_WIDTH = 32
) (
  input  logic               clk,
  input  logic               ce_i,
  input  logic [C_WIDTH-1:0] data_i,
  output logic [C_WIDTH-1:0] data_o
);

  logic [C_WIDTH-1:0] line_q [C_DEPTH];

  // Shift every slot one position toward the tail whenever the line advances.
  always_ff @(posedge clk) begin
    if (ce_i) begin
      line_q[0] <= data_i;
      for (int i = 1; i < C_DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign data_o = line_q[C_DEPTH-1];

endmodule

// File: rtl/srl_pipe_ctrl.sv
// Valid/ready sequencer around a fixed-latency delay line. A parallel valid
// shift register marks live slots; the whole line freezes only when a live
// word sits at the tail and the consumer stalls. Also keeps an occupancy
// count and a small FSM that sequences drain requests.
module srl_pipe_ctrl
  import srl_pkg::*;
#(
  parameter int C_CLOCK_CYCLES = 4,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_CNT_WIDTH    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [C_DATA_WIDTH-1:0] m_data,
  input  logic                    drain_req,
  output logic                    drain_done,
  input  logic                    flush,
  output logic [C_CNT_WIDTH-1:0]  occupancy,
  output logic                    busy
);

  localparam int N = C_CLOCK_CYCLES;

  // Reject unsupported depths and counters too narrow to hold N.
  if (!depth_ok(C_CLOCK_CYCLES)) begin : g_bad_depth
    $error("srl_pipe_ctrl: C_CLOCK_CYCLES out of supported range");
  end
  if ((64'd1 << C_CNT_WIDTH) <= 64'(C_CLOCK_CYCLES)) begin : g_bad_cnt
    $error("srl_pipe_ctrl: C_CNT_WIDTH too small for C_CLOCK_CYCLES");
  end

  srl_state_e             state_q, state_d;
  logic [N-1:0]           vld_q, vld_d;
  logic [C_CNT_WIDTH-1:0] occ_q, occ_d;
  logic                   ce_s;
  logic                   in_xfer_s;
  logic                   out_xfer_s;

  // Line advances unless a live tail word is being held off by the consumer.
  assign ce_s       = ~vld_q[N-1] | m_ready;
  assign s_ready    = ce_s & (state_q != S_DRAIN);
  assign in_xfer_s  = s_valid & s_ready;
  assign out_xfer_s = vld_q[N-1] & m_ready;

  assign m_valid    = vld_q[N-1];
  assign occupancy  = occ_q;
  assign drain_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) | (occ_q != '0);

  srl_pipe_payload #(
    .C_DEPTH (N),
    .C_WIDTH (C_DATA_WIDTH)
  ) u_payload (
    .clk    (clk),
    .ce_i   (ce_s),
    .data_i (s_data),
    .data_o (m_data)
  );

  // Next valid vector and occupancy; flush wipes both regardless of traffic.
  always_comb begin
    vld_d = vld_q;
    occ_d = occ_q;
    if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end else begin
      if (ce_s) begin
        vld_d = {vld_q[N-2:0], in_xfer_s};
      end else begin
        vld_d = vld_q;
      end
      case ({in_xfer_s, out_xfer_s})
        2'b10:   occ_d = occ_q + C_CNT_WIDTH'(1'b1);
        2'b01:   occ_d = occ_q - C_CNT_WIDTH'(1'b1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Drain sequencing; flush aborts everything and drain_req beats traffic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (drain_req) begin
            state_d = S_DRAIN;
          end else if (in_xfer_s) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (drain_req) begin
            state_d = S_DRAIN;
          end else if (occ_d == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (occ_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state registers; payload bits are deliberately not reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_srl_pipe_ctrl.sv
// Bench for srl_pipe_ctrl: directed scenarios on a depth-4 instance plus
// randomized traffic on depth-2 and depth-8 instances against a queue model.
module tb_srl_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv    [3];
  logic        sr    [3];
  logic [31:0] sd    [3];
  logic        mv    [3];
  logic        mr    [3];
  logic [31:0] md    [3];
  logic        dreq  [3];
  logic        ddone [3];
  logic        fl    [3];
  logic [6:0]  occ   [3];
  logic        bsy   [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    srl_pipe_ctrl #(
      .C_CLOCK_CYCLES ((g == 0) ? 4 : ((g == 1) ? 2 : 8)),
      .C_DATA_WIDTH   (32),
      .C_CNT_WIDTH    (7)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (sv[g]),
      .s_ready    (sr[g]),
      .s_data     (sd[g]),
      .m_valid    (mv[g]),
      .m_ready    (mr[g]),
      .m_data     (md[g]),
      .drain_req  (dreq[g]),
      .drain_done (ddone[g]),
      .flush      (fl[g]),
      .occupancy  (occ[g]),
      .busy       (bsy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; sd[k] = 32'd0; mr[k] = 1'b0; dreq[k] = 1'b0; fl[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #12;
    n_checks++; if (mv[0] !== 1'b0) $display("FAIL reset_m_valid got %0b want 0", mv[0]); else n_pass++;
    n_checks++; if (occ[0] !== 7'd0) $display("FAIL reset_occupancy got %0d want 0", occ[0]); else n_pass++;
    n_checks++; if (bsy[0] !== 1'b0) $display("FAIL reset_busy got %0b want 0", bsy[0]); else n_pass++;
    n_checks++; if (ddone[0] !== 1'b0) $display("FAIL reset_drain_done got %0b want 0", ddone[0]); else n_pass++;
    n_checks++; if (sr[0] !== 1'b1) $display("FAIL reset_s_ready got %0b want 1", sr[0]); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int peak = 0;
    clear_inputs();
    for (int c = 0; c < 14; c++) begin
      int acc, emi;
      sv[0] = (c < 8); sd[0] = 32'(c); mr[0] = 1'b1;
      #2;
      acc = (c < 8) ? c : 8;
      emi = (c <= 4) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
      n_checks++; if (sr[0] !== 1'b1) $display("FAIL stream_s_ready c=%0d got %0b want 1", c, sr[0]); else n_pass++;
      n_checks++; if (mv[0] !== ((c >= 4) && (c < 12))) $display("FAIL stream_m_valid c=%0d got %0b", c, mv[0]); else n_pass++;
      if ((c >= 4) && (c < 12)) begin
        n_checks++; if (md[0] !== 32'(c - 4)) $display("FAIL stream_m_data c=%0d got %0d want %0d", c, md[0], c - 4); else n_pass++;
      end
      n_checks++; if (occ[0] !== 7'(acc - emi)) $display("FAIL stream_occupancy c=%0d got %0d want %0d", c, occ[0], acc - emi); else n_pass++;
      if (int'(occ[0]) > peak) peak = int'(occ[0]);
      tick();
    end
    n_checks++; if (peak !== 4) $display("FAIL stream_peak_occupancy got %0d want 4", peak); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] tab [4];
    tab[0] = 32'hA0A0_0001; tab[1] = 32'hB0B0_0002; tab[2] = 32'hC0C0_0003; tab[3] = 32'hD0D0_0004;
    clear_inputs();
    for (int c = 0; c < 14; c++) begin
      sv[0] = (c < 9);
      sd[0] = (c < 4) ? tab[c] : (32'hDEAD_0000 + 32'(c));
      mr[0] = (c >= 9);
      #2;
      if (c < 4) begin
        n_checks++; if (sr[0] !== 1'b1) $display("FAIL bp_fill_s_ready c=%0d got %0b want 1", c, sr[0]); else n_pass++;
      end else if (c < 9) begin
        n_checks++; if (sr[0] !== 1'b0) $display("FAIL bp_stall_s_ready c=%0d got %0b want 0", c, sr[0]); else n_pass++;
        n_checks++; if (mv[0] !== 1'b1) $display("FAIL bp_stall_m_valid c=%0d got %0b want 1", c, mv[0]); else n_pass++;
        n_checks++; if (md[0] !== tab[0]) $display("FAIL bp_stall_m_data c=%0d got %h want %h", c, md[0], tab[0]); else n_pass++;
        n_checks++; if (occ[0] !== 7'd4) $display("FAIL bp_stall_occupancy c=%0d got %0d want 4", c, occ[0]); else n_pass++;
      end else if (c < 13) begin
        n_checks++; if (mv[0] !== 1'b1) $display("FAIL bp_release_m_valid c=%0d got %0b want 1", c, mv[0]); else n_pass++;
        n_checks++; if (md[0] !== tab[c-9]) $display("FAIL bp_release_m_data c=%0d got %h want %h", c, md[0], tab[c-9]); else n_pass++;
        if (c == 9) begin
          n_checks++; if (sr[0] !== 1'b1) $display("FAIL bp_release_s_ready got %0b want 1", sr[0]); else n_pass++;
        end
      end else begin
        n_checks++; if (mv[0] !== 1'b0) $display("FAIL bp_empty_m_valid got %0b want 0", mv[0]); else n_pass++;
        n_checks++; if (occ[0] !== 7'd0) $display("FAIL bp_empty_occupancy got %0d want 0", occ[0]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_drain();
    int exp_occ [8];
    exp_occ = '{0, 1, 2, 3, 3, 2, 1, 0};
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      sv[0] = (c < 7); sd[0] = 32'(100 + c); mr[0] = 1'b1; dreq[0] = (c == 2);
      #2;
      n_checks++; if (sr[0] !== !((c >= 3) && (c <= 6))) $display("FAIL drain_s_ready c=%0d got %0b", c, sr[0]); else n_pass++;
      n_checks++; if (mv[0] !== ((c >= 4) && (c <= 6))) $display("FAIL drain_m_valid c=%0d got %0b", c, mv[0]); else n_pass++;
      if ((c >= 4) && (c <= 6)) begin
        n_checks++; if (md[0] !== 32'(100 + c - 4)) $display("FAIL drain_m_data c=%0d got %0d want %0d", c, md[0], 100 + c - 4); else n_pass++;
      end
      n_checks++; if (ddone[0] !== (c == 7)) $display("FAIL drain_done c=%0d got %0b", c, ddone[0]); else n_pass++;
      n_checks++; if (bsy[0] !== ((c >= 1) && (c <= 7))) $display("FAIL drain_busy c=%0d got %0b", c, bsy[0]); else n_pass++;
      if (c < 8) begin
        n_checks++; if (occ[0] !== 7'(exp_occ[c])) $display("FAIL drain_occupancy c=%0d got %0d want %0d", c, occ[0], exp_occ[c]); else n_pass++;
      end
      tick();
    end
    // Drain of an already-empty line still passes through DRAIN then DONE.
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      dreq[0] = (c == 0);
      #2;
      if (c == 1) begin
        n_checks++; if (sr[0] !== 1'b0) $display("FAIL idle_drain_s_ready got %0b want 0", sr[0]); else n_pass++;
        n_checks++; if (bsy[0] !== 1'b1) $display("FAIL idle_drain_busy got %0b want 1", bsy[0]); else n_pass++;
      end
      n_checks++; if (ddone[0] !== (c == 2)) $display("FAIL idle_drain_done c=%0d got %0b", c, ddone[0]); else n_pass++;
      if (c == 3) begin
        n_checks++; if (bsy[0] !== 1'b0) $display("FAIL idle_drain_end_busy got %0b want 0", bsy[0]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    for (int c = 0; c < 9; c++) begin
      sv[0] = (c <= 3); sd[0] = 32'(200 + c); mr[0] = 1'b1; fl[0] = (c == 3);
      #2;
      if (c == 3) begin
        n_checks++; if (occ[0] !== 7'd3) $display("FAIL flush_pre_occupancy got %0d want 3", occ[0]); else n_pass++;
        n_checks++; if (sr[0] !== 1'b1) $display("FAIL flush_pre_s_ready got %0b want 1", sr[0]); else n_pass++;
      end else if (c > 3) begin
        n_checks++; if (occ[0] !== 7'd0) $display("FAIL flush_occupancy c=%0d got %0d want 0", c, occ[0]); else n_pass++;
        n_checks++; if (mv[0] !== 1'b0) $display("FAIL flush_m_valid c=%0d got %0b want 0", c, mv[0]); else n_pass++;
        n_checks++; if (bsy[0] !== 1'b0) $display("FAIL flush_busy c=%0d got %0b want 0", c, bsy[0]); else n_pass++;
      end
      tick();
    end
    // Flush while a drain is pending must abort it silently.
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      sv[0] = (c <= 2); sd[0] = 32'(300 + c); mr[0] = 1'b0; dreq[0] = (c == 2); fl[0] = (c == 3);
      #2;
      n_checks++; if (ddone[0] !== 1'b0) $display("FAIL flush_drain_done c=%0d got %0b want 0", c, ddone[0]); else n_pass++;
      if (c == 3) begin
        n_checks++; if (sr[0] !== 1'b0) $display("FAIL flush_drain_s_ready got %0b want 0", sr[0]); else n_pass++;
        n_checks++; if (occ[0] !== 7'd3) $display("FAIL flush_drain_pre_occ got %0d want 3", occ[0]); else n_pass++;
      end else if (c > 3) begin
        n_checks++; if (occ[0] !== 7'd0) $display("FAIL flush_drain_occ c=%0d got %0d want 0", c, occ[0]); else n_pass++;
        n_checks++; if (mv[0] !== 1'b0) $display("FAIL flush_drain_m_valid c=%0d got %0b want 0", c, mv[0]); else n_pass++;
        n_checks++; if (bsy[0] !== 1'b0) $display("FAIL flush_drain_busy c=%0d got %0b want 0", c, bsy[0]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      sv[0] = (c < 2); sd[0] = 32'(400 + c); mr[0] = 1'b1;
      tick();
    end
    sv[0] = 1'b0; mr[0] = 1'b0;
    #2;
    n_checks++; if (mv[0] !== 1'b1) $display("FAIL areset_pre_m_valid got %0b want 1", mv[0]); else n_pass++;
    n_checks++; if (occ[0] !== 7'd2) $display("FAIL areset_pre_occupancy got %0d want 2", occ[0]); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (mv[0] !== 1'b0) $display("FAIL areset_m_valid got %0b want 0", mv[0]); else n_pass++;
    n_checks++; if (bsy[0] !== 1'b0) $display("FAIL areset_busy got %0b want 0", bsy[0]); else n_pass++;
    n_checks++; if (occ[0] !== 7'd0) $display("FAIL areset_occupancy got %0d want 0", occ[0]); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sv[0] = (c == 0); sd[0] = 32'h5A5A_0000 + 32'(c); mr[0] = 1'b1;
      #2;
      n_checks++; if (mv[0] !== (c == 4)) $display("FAIL areset_latency_m_valid c=%0d got %0b", c, mv[0]); else n_pass++;
      if (c == 4) begin
        n_checks++; if (md[0] !== 32'h5A5A_0000) $display("FAIL areset_latency_m_data got %h want 5a5a0000", md[0]); else n_pass++;
      end
      tick();
    end
  endtask

  // Queue model: each live word remembers how many line advances remain
  // before it reaches the tail; the line advances unless the tail word stalls.
  task automatic test_random(input int k, input int n);
    logic [31:0] q_data [$];
    int          q_rem  [$];
    int          out_cnt = 0;
    int          dut_out = 0;
    logic        tail_live, ce;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int phase = (cyc / 400) % 3;
      sv[k] = ($urandom_range(0, 9) < ((phase == 0) ? 9 : ((phase == 1) ? 3 : 6)));
      mr[k] = ($urandom_range(0, 9) < ((phase == 0) ? 3 : ((phase == 1) ? 9 : 6)));
      sd[k] = $urandom();
      tail_live = (q_data.size() > 0) && (q_rem[0] == 0);
      ce = !tail_live || mr[k];
      #2;
      n_checks++; if (sr[k] !== ce) $display("FAIL rand%0d_s_ready cyc=%0d got %0b want %0b", n, cyc, sr[k], ce); else n_pass++;
      n_checks++; if (mv[k] !== tail_live) $display("FAIL rand%0d_m_valid cyc=%0d got %0b want %0b", n, cyc, mv[k], tail_live); else n_pass++;
      if (tail_live) begin
        n_checks++; if (md[k] !== q_data[0]) $display("FAIL rand%0d_m_data cyc=%0d got %h want %h", n, cyc, md[k], q_data[0]); else n_pass++;
      end
      n_checks++; if (occ[k] !== 7'(q_data.size())) $display("FAIL rand%0d_occupancy cyc=%0d got %0d want %0d", n, cyc, occ[k], q_data.size()); else n_pass++;
      n_checks++; if (int'(occ[k]) > n) $display("FAIL rand%0d_occ_bound cyc=%0d got %0d max %0d", n, cyc, occ[k], n); else n_pass++;
      if ((mv[k] === 1'b1) && mr[k]) dut_out++;
      if (ce) begin
        if (tail_live && mr[k]) begin
          void'(q_data.pop_front());
          void'(q_rem.pop_front());
          out_cnt++;
        end
        for (int i = 0; i < q_rem.size(); i++) begin
          if (q_rem[i] > 0) q_rem[i] = q_rem[i] - 1;
        end
        if (sv[k]) begin
          q_data.push_back(sd[k]);
          q_rem.push_back(n - 1);
        end
      end
      tick();
    end
    n_checks++; if (dut_out !== out_cnt) $display("FAIL rand%0d_out_count got %0d want %0d", n, dut_out, out_cnt); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_flush();
    test_async_reset();
    test_random(1, 2);
    test_random(2, 8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
